// File: rtl/tcdm_bank_adapter.sv
// Terminal TCDM stage: grants requests only against free response credits, drives a
// 1-cycle-latency SRAM and returns one response per grant through a circular FIFO.
module tcdm_bank_adapter #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32,
  parameter int RESP_DEPTH = 3,
  localparam int BE_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  slv_req_i,
  output logic                  slv_gnt_o,
  input  logic [ADDR_WIDTH-1:0] slv_addr_i,
  input  logic                  slv_wen_i,
  input  logic [BE_WIDTH-1:0]   slv_be_i,
  input  logic [DATA_WIDTH-1:0] slv_data_i,
  input  logic                  slv_r_ready_i,
  output logic [DATA_WIDTH-1:0] slv_r_data_o,
  output logic                  slv_r_valid_o,
  output logic                  sram_req_o,
  output logic                  sram_we_o,
  output logic [ADDR_WIDTH-1:0] sram_addr_o,
  output logic [DATA_WIDTH-1:0] sram_wdata_o,
  output logic [BE_WIDTH-1:0]   sram_be_o,
  input  logic [DATA_WIDTH-1:0] sram_rdata_i,
  output logic                  busy_o
);

  localparam int CNT_W = $clog2(RESP_DEPTH + 1);
  localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W + 1)'(RESP_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(RESP_DEPTH - 1);

  logic [CNT_W-1:0]      count;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  vld_p1;
  logic                  is_read_p1;
  logic [DATA_WIDTH-1:0] fifo_mem [RESP_DEPTH];
  logic [CNT_W:0]        credits_used;
  logic                  push;
  logic                  pop;

  // Pointers wrap explicitly so non-power-of-2 depths work.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (p == LAST_PTR) return '0;
    return p + PTR_W'(1);
  endfunction

  // Stage p0: credit check and SRAM access in the grant cycle.
  assign credits_used = {1'b0, count} + {{CNT_W{1'b0}}, vld_p1};
  assign slv_gnt_o    = slv_req_i && rstn_i && (credits_used < DEPTH_C);
  assign sram_req_o   = slv_req_i && slv_gnt_o;
  assign sram_we_o    = !slv_wen_i;
  assign sram_addr_o  = slv_addr_i;
  assign sram_wdata_o = slv_data_i;
  assign sram_be_o    = slv_be_i;

  assign push          = vld_p1;
  assign slv_r_valid_o = (count != '0);
  assign pop           = slv_r_valid_o && slv_r_ready_i;
  assign slv_r_data_o  = fifo_mem[rd_ptr];
  assign busy_o        = (count != '0) || vld_p1;

  // Stage p1: access in flight; control state only is reset.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      vld_p1     <= 1'b0;
      is_read_p1 <= 1'b0;
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      vld_p1     <= slv_gnt_o;
      is_read_p1 <= slv_wen_i;
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Stage p2: response captured into the FIFO; writes answer with zero.
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr] <= is_read_p1 ? sram_rdata_i : '0;
  end

endmodule

// File: tb/tb_tcdm_bank_adapter.sv
// Bench for tcdm_bank_adapter: four instances (depths 3,1,2,5) each with an SRAM model
// and a queue-based reference; directed table and sequences on depth 3, random on all.
module tb_tcdm_bank_adapter;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } resp_t;

  typedef struct {
    logic        req;
    logic        wen;
    logic [10:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        exp_gnt;
    logic        exp_vld;
    logic        exp_busy;
    logic [31:0] exp_data;
  } vec_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        drain_chk = 1'b0;
  int          cyc = 0;
  int          n_vec = 0;
  int          n_bad = 0;

  logic        req [4], gnt [4], wen [4], rready [4], rvalid [4];
  logic        sreq [4], swe [4], busy [4];
  logic [10:0] addr [4], saddr [4];
  logic [3:0]  be [4], sbe [4];
  logic [31:0] wdata [4], rdata [4], swdata [4], srdata [4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check1(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : g_inst
    localparam int D = (g == 0) ? 3 : (g == 1) ? 1 : (g == 2) ? 2 : 5;

    tcdm_bank_adapter #(.ADDR_WIDTH(11), .DATA_WIDTH(32), .RESP_DEPTH(D)) u_dut (
      .clk_i(clk), .rstn_i(rstn),
      .slv_req_i(req[g]), .slv_gnt_o(gnt[g]), .slv_addr_i(addr[g]), .slv_wen_i(wen[g]),
      .slv_be_i(be[g]), .slv_data_i(wdata[g]), .slv_r_ready_i(rready[g]),
      .slv_r_data_o(rdata[g]), .slv_r_valid_o(rvalid[g]),
      .sram_req_o(sreq[g]), .sram_we_o(swe[g]), .sram_addr_o(saddr[g]),
      .sram_wdata_o(swdata[g]), .sram_be_o(sbe[g]), .sram_rdata_i(srdata[g]),
      .busy_o(busy[g])
    );

    logic [31:0] sram [2048];
    logic [31:0] refmem [2048];
    resp_t       q [$];
    int          n_gnt = 0;
    int          n_pop = 0;

    initial for (int k = 0; k < 2048; k++) begin
      sram[k]   = 32'h0;
      refmem[k] = 32'h0;
    end

    // SRAM macro model: 1-cycle read latency, byte-masked writes.
    always @(posedge clk) begin
      if (sreq[g]) begin
        if (swe[g]) begin
          for (int b = 0; b < 4; b++)
            if (sbe[g][b]) sram[saddr[g]][8*b +: 8] <= swdata[g][8*b +: 8];
        end else begin
          srdata[g] <= sram[saddr[g]];
        end
      end
    end

    // Reference: outstanding responses = queue; visible two cycles after their grant.
    always @(negedge clk) begin
      logic  eg;
      logic  ev;
      resp_t e;
      if (!rstn) begin
        check1("rst_gnt", gnt[g], 1'b0);
        check1("rst_sram_req", sreq[g], 1'b0);
        q.delete();
        n_gnt = 0;
        n_pop = 0;
      end else begin
        eg = req[g] && (q.size() < D);
        ev = (q.size() != 0) && (q[0].cyc <= cyc - 2);
        check1("gnt", gnt[g], eg);
        check1("sram_req", sreq[g], eg);
        check1("r_valid", rvalid[g], ev);
        check1("busy", busy[g], q.size() != 0);
        if (ev && rvalid[g]) check32("r_data", rdata[g], q[0].data);
        if (ev && rready[g]) begin
          void'(q.pop_front());
          n_pop++;
        end
        if (gnt[g]) begin
          check1("sram_we", swe[g], !wen[g]);
          e.cyc = cyc;
          if (wen[g]) begin
            e.data = refmem[addr[g]];
          end else begin
            e.data = 32'h0;
            for (int b = 0; b < 4; b++)
              if (be[g][b]) refmem[addr[g]][8*b +: 8] = wdata[g][8*b +: 8];
          end
          q.push_back(e);
          n_gnt++;
        end
      end
    end

    always @(negedge clk)
      if (rstn && u_dut.vld_p1) check1("no_overflow", (u_dut.count == D), 1'b0);

    always @(posedge drain_chk) begin
      check32("gnt_vs_resp", n_gnt, n_pop);
      check32("q_empty", q.size(), 0);
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int t = 0;
    for (int i = 0; i < 4; i++) req[i] = 1'b0;
    rready[0] = 1'b1;
    while (busy[0] && t < 40) begin
      nxt();
      t++;
    end
    check1("drain_idle", busy[0], 1'b0);
  endtask

  initial begin
    vec_t tbl [8];
    int   na;

    tbl[0] = '{1'b1, 1'b0, 11'h005, 4'hF, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[1] = '{1'b1, 1'b1, 11'h005, 4'h0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h0};
    tbl[2] = '{1'b1, 1'b0, 11'h010, 4'hF, 32'h11223344, 1'b1, 1'b1, 1'b1, 32'h0};
    tbl[3] = '{1'b1, 1'b0, 11'h010, 4'h2, 32'hAABBCCDD, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF};
    tbl[4] = '{1'b1, 1'b1, 11'h010, 4'h0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h0};
    tbl[5] = '{1'b0, 1'b1, 11'h000, 4'h0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h0};
    tbl[6] = '{1'b0, 1'b1, 11'h000, 4'h0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h1122CC44};
    tbl[7] = '{1'b0, 1'b1, 11'h000, 4'h0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0};

    for (int i = 0; i < 4; i++) begin
      req[i] = 1'b0; wen[i] = 1'b1; addr[i] = '0; be[i] = '0; wdata[i] = '0; rready[i] = 1'b1;
    end
    rstn   = 1'b0;
    req[0] = 1'b1;

    // Reset: requests must be refused while rstn is low.
    repeat (3) begin
      @(negedge clk);
      check1("reset_gnt", gnt[0], 1'b0);
      check1("reset_sram_req", sreq[0], 1'b0);
      nxt();
    end
    rstn   = 1'b1;
    req[0] = 1'b0;
    check1("post_reset_valid", rvalid[0], 1'b0);
    check1("post_reset_busy", busy[0], 1'b0);
    nxt();

    // Write-then-read and byte-enable table.
    for (int k = 0; k < 8; k++) begin
      req[0] = tbl[k].req; wen[0] = tbl[k].wen; addr[0] = tbl[k].addr;
      be[0] = tbl[k].be; wdata[0] = tbl[k].wdata;
      @(negedge clk);
      check1("tbl_gnt", gnt[0], tbl[k].exp_gnt);
      check1("tbl_valid", rvalid[0], tbl[k].exp_vld);
      check1("tbl_busy", busy[0], tbl[k].exp_busy);
      if (tbl[k].exp_vld) check32("tbl_data", rdata[0], tbl[k].exp_data);
      nxt();
    end

    // Streaming: preload addr*3, then 8 back-to-back reads.
    for (int k = 0; k < 8; k++) begin
      req[0] = 1'b1; wen[0] = 1'b0; addr[0] = 11'(k); be[0] = 4'hF; wdata[0] = 32'(k * 3);
      nxt();
    end
    drain();
    for (int c = 0; c < 12; c++) begin
      req[0] = (c < 8); wen[0] = 1'b1; addr[0] = 11'(c);
      @(negedge clk);
      check1("stream_gnt", gnt[0], c < 8);
      check1("stream_valid", rvalid[0], (c >= 2) && (c < 10));
      if ((c >= 2) && (c < 10)) check32("stream_data", rdata[0], 32'((c - 2) * 3));
      nxt();
    end

    // Backpressure: three credits, then hold; resume after first pop.
    drain();
    rready[0] = 1'b0;
    na = 3;
    for (int c = 0; c < 14; c++) begin
      req[0] = 1'b1; wen[0] = 1'b1; addr[0] = 11'(na);
      @(negedge clk);
      check1("bp_gnt", gnt[0], c < 3);
      if (c >= 2) check32("bp_hold_data", rdata[0], 32'd9);
      if (c == 13) check32("bp_count", 32'(g_inst[0].u_dut.count), 32'd3);
      if (gnt[0]) na++;
      nxt();
    end
    rready[0] = 1'b1;
    for (int r = 0; r < 3; r++) begin
      addr[0] = 11'(na);
      @(negedge clk);
      check1("bp_resume_gnt", gnt[0], r > 0);
      check32("bp_pop_data", rdata[0], 32'(9 + 3 * r));
      if (gnt[0]) na++;
      nxt();
    end
    drain();

    // Reset with two responses queued and one read in flight.
    rready[0] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      req[0] = 1'b1; wen[0] = 1'b1; addr[0] = 11'(c + 1);
      @(negedge clk);
      check1("mid_gnt", gnt[0], 1'b1);
      nxt();
    end
    req[0] = 1'b0;
    check32("mid_count", 32'(g_inst[0].u_dut.count), 32'd2);
    check1("mid_busy", busy[0], 1'b1);
    rstn = 1'b0;
    nxt();
    rstn = 1'b1;
    check1("mid_rst_valid", rvalid[0], 1'b0);
    check1("mid_rst_busy", busy[0], 1'b0);
    rready[0] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check1("mid_no_stale", rvalid[0], 1'b0);
      nxt();
    end
    req[0] = 1'b1; wen[0] = 1'b1; addr[0] = 11'h010;
    @(negedge clk);
    check1("post_rst_gnt", gnt[0], 1'b1);
    nxt();
    req[0] = 1'b0;
    @(negedge clk);
    check1("post_rst_n1_valid", rvalid[0], 1'b0);
    nxt();
    @(negedge clk);
    check1("post_rst_n2_valid", rvalid[0], 1'b1);
    check32("post_rst_data", rdata[0], 32'h1122CC44);
    nxt();

    // Random stress across all four depths.
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < 4; i++) begin
        req[i]    = ($urandom_range(0, 3) != 0);
        wen[i]    = $urandom_range(0, 1) != 0;
        addr[i]   = 11'($urandom_range(0, 15));
        be[i]     = 4'($urandom);
        wdata[i]  = $urandom;
        rready[i] = ($urandom_range(0, 3) != 0);
      end
      nxt();
    end
    for (int i = 0; i < 4; i++) begin
      req[i]    = 1'b0;
      rready[i] = 1'b1;
    end
    repeat (30) nxt();
    drain_chk = 1'b1;
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/tcdm_bank_adapter.md
# tcdm_bank_adapter

Terminal TCDM stage directly downstream of the TCDM pipeline slice: accepts the slice's master-side req/gnt requests, drives a single-port SRAM macro with 1-cycle read latency, and returns exactly one response per granted request through a credit-protected response FIFO. The FIFO honours the `r_ready` backpressure that the slice passes through unregistered. Grants are issued only when a response slot is guaranteed, so no response is ever dropped.

## Interface
- `ADDR_WIDTH`, 11, word address width; equals SRAM depth log2.
- `DATA_WIDTH`, 32, data width; multiple of 8.
- `RESP_DEPTH`, 3, response FIFO entries, ≥1; ≥3 gives full throughput.
- `BE_WIDTH` (localparam), `DATA_WIDTH/8`.
- `clk_i`  in  1  single clock, all state on rising edge.
- `rstn_i`  in  1  reset; synchronous, active-low.
- `slv_req_i`  in  1  request valid from slice.
- `slv_gnt_o`  out  1  request accepted this cycle.
- `slv_addr_i`  in  ADDR_WIDTH  word address.
- `slv_wen_i`  in  1  1 = read, 0 = write.
- `slv_be_i`  in  BE_WIDTH  write byte enables.
- `slv_data_i`  in  DATA_WIDTH  write data.
- `slv_r_ready_i`  in  1  consumer ready for response.
- `slv_r_data_o`  out  DATA_WIDTH  response data; read data, or 0 for writes.
- `slv_r_valid_o`  out  1  response valid.
- `sram_req_o`  out  1  SRAM chip enable.
- `sram_we_o`  out  1  SRAM write enable, active-high.
- `sram_addr_o`  out  ADDR_WIDTH  SRAM address.
- `sram_wdata_o`  out  DATA_WIDTH  SRAM write data.
- `sram_be_o`  out  BE_WIDTH  SRAM byte enables.
- `sram_rdata_i`  in  DATA_WIDTH  SRAM read data, valid the cycle after a read access.
- `busy_o`  out  1  FIFO non-empty or access in flight.

## Operation
- Credit rule: `slv_gnt_o = slv_req_i && rstn_i && (fifo_count + inflight < RESP_DEPTH)`.
  - `slv_gnt_o` has no combinational dependency on `slv_r_ready_i`.
- Access: `sram_req_o = slv_req_i && slv_gnt_o`, combinational in the grant cycle.
  - `sram_we_o = !slv_wen_i`.
  - `sram_addr_o`, `sram_wdata_o` and `sram_be_o` pass through from the slave inputs.
- In-flight register (1 bit): `inflight` <= granted this cycle; `inflight_is_read` <= `slv_wen_i`.
- Capture: in the cycle after a grant (`inflight == 1`), push one FIFO entry.
  - Read: entry = `sram_rdata_i`.
  - Write: entry = 0.
- Every granted request, read or write, produces exactly one response, in grant order.
- FIFO:
  - Circular buffer of `RESP_DEPTH` entries; read and write pointers wrap from `RESP_DEPTH-1` to 0, so non-power-of-2 depths are legal.
  - `fifo_count` width is `$clog2(RESP_DEPTH+1)`.
  - `slv_r_valid_o = (fifo_count != 0)`; `slv_r_data_o` = head entry.
  - Pop when `slv_r_valid_o && slv_r_ready_i`.
- Simultaneous push and pop: count unchanged, both pointers advance; legal when full or empty.
  - When empty, the pushed data is not bypassed; it appears on the next cycle.
- Overflow is impossible by the credit rule. The bench asserts that a push never occurs with `fifo_count == RESP_DEPTH`.
- `slv_r_valid_o` stays asserted and `slv_r_data_o` stays stable until popped (no retraction).
- `busy_o = (fifo_count != 0) || inflight`.

## Timing
- Reset (`rstn_i == 0` at a clock edge):
  - Pointers, `fifo_count`, `inflight` and `inflight_is_read` are cleared.
  - FIFO data is not reset.
- While `rstn_i` is low: `slv_gnt_o = 0` and `sram_req_o = 0`.
- After reset: `slv_r_valid_o = 0` and `busy_o = 0`. `slv_r_data_o` follows the head entry and is don't-care while `slv_r_valid_o = 0`.
- Reset mid-operation discards all queued and in-flight responses; `slv_r_valid_o = 0` in the cycle after the reset edge.
- Latency: grant in cycle N → SRAM access in N → data captured at the end of N+1 → `slv_r_valid_o` in N+2. Minimum is 2 cycles.
- Throughput: with `RESP_DEPTH ≥ 3` and `slv_r_ready_i` held high, one grant per cycle.
  - `RESP_DEPTH = 2` yields 2 grants per 3 cycles; `RESP_DEPTH = 1` yields 1 per 3.
- Backpressure: with `slv_r_ready_i` low, `slv_gnt_o` drops once `fifo_count + inflight == RESP_DEPTH`.
  - Grants resume in the cycle after the first pop.

## Test plan
- **Write then read.** Write addr 0x005, data 0xDEADBEEF, be 0xF; then read 0x005.
  - Each grant is immediate.
  - Write response has r_data 0 at N+2.
  - Read response has r_data 0xDEADBEEF at N'+2.
- **Byte enables.** Write 0x11223344 to 0x010, then be 0x2 data 0xAABBCCDD; then read 0x010 → 0x1122CC44.
- **Streaming.** `RESP_DEPTH = 3`, `r_ready` = 1, 8 back-to-back reads of addr 0..7 preloaded with addr×3.
  - `slv_gnt_o` high for 8 consecutive cycles.
  - `r_valid` high 8 consecutive cycles starting 2 cycles later; data 0,3,…,21 in order.
- **Backpressure.** `r_ready` = 0, continuous reads.
  - Exactly 3 grants, then `slv_gnt_o` = 0 and `fifo_count` = 3.
  - `r_data` holds stable for 10 cycles.
  - Raise `r_ready`: pops in order, grant resumes the cycle after the first pop, no loss or duplication.
- **Reset mid-operation.** With 2 responses queued and 1 in flight, pulse `rstn_i` low for 1 cycle.
  - `slv_r_valid_o` = 0 and `busy_o` = 0 the next cycle.
  - No stale response afterwards; a subsequent read returns correct data.
- **Random stress.** Random req/wen/be/`r_ready`, `RESP_DEPTH` ∈ {1,2,5}, scoreboard against a reference memory.
  - Grant count equals response count.
  - No overflow assertion fires.
